dmem_responder: RTL and testbench



---
 rtl/dmem_pkg.sv | 26 ++
 rtl/dmem_responder_if.sv | 23 ++
 rtl/dmem_array.sv | 28 ++
 rtl/dmem_responder.sv | 102 ++++++++++
 tb/tb_dmem_responder.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Latency: n/a (package only); backpressure: n/a.
package dmem_pkg;

    localparam int WORD_W         = 32;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Request fields frozen at acceptance; be is all-ones when strobes are absent.
    typedef struct packed {
        logic                      we;
        logic [WORD_W-1:0]         addr;
        logic [WORD_W-1:0]         wdata;
        logic [BYTES_PER_WORD-1:0] be;
    } req_t;

    function automatic logic is_misaligned(input logic [WORD_W-1:0] a);
        return (a[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Memory-stage request/response bus; be exists only with DMEM_BYTE_STROBE_EN.
// Master = pipeline initiator, slave = dmem_responder; req held until ready.
interface dmem_responder_if;

    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        err;
    logic        stall;
`ifdef DMEM_BYTE_STROBE_EN
    logic [3:0]  be;

    modport master (output req, we, addr, wdata, be, input rdata, ready, err, stall);
    modport slave  (input req, we, addr, wdata, be, output rdata, ready, err, stall);
`else
    modport master (output req, we, addr, wdata, input rdata, ready, err, stall);
    modport slave  (input req, we, addr, wdata, output rdata, ready, err, stall);
`endif

endinterface

// File: rtl/dmem_array.sv
// Single-port word storage, per-byte write enables, no reset.
// Latency: write on the clock edge, read combinational; no backpressure.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic                      clk,
    input  logic [BYTES_PER_WORD-1:0] i_be,
    input  logic [IDX_W-1:0]          i_idx,
    input  logic [WORD_W-1:0]         i_wdata,
    output logic [WORD_W-1:0]         o_rdata
);

    logic [WORD_W-1:0] r_mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        for (int b = 0; b < BYTES_PER_WORD; b++) begin
            if (i_be[b]) begin
                r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
            end
        end
    end

    assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one word access, answers after WAIT_CYCLES+1 edges
// with a one-cycle ready pulse; stall = req & ~ready. DMEM_BYTE_STROBE_EN adds be.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 1,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic       clka,
    input  logic       rst,
    dmem_responder_if.slave bus
);

    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES);

    state_t                      r_state;
    logic [3:0]                  r_cnt;
    req_t                        r_req;
    logic [WORD_W-1:0]           r_rdata;
    logic                        r_ready;
    logic                        r_err;

    logic [IDX_W-1:0]            w_idx;
    logic                        w_misal;
    logic                        w_access;
    logic [BYTES_PER_WORD-1:0]   w_wr_be;
    logic [WORD_W-1:0]           w_rd_word;
    logic [BYTES_PER_WORD-1:0]   w_in_be;

`ifdef DMEM_BYTE_STROBE_EN
    assign w_in_be = bus.be;
`else
    assign w_in_be = '1;
`endif

    assign w_idx    = r_req.addr[IDX_W+1:2];
    assign w_misal  = is_misaligned(r_req.addr);
    assign w_access = (r_state == WAIT) && (r_cnt == 4'd0);
    assign w_wr_be  = (w_access && r_req.we && !w_misal) ? r_req.be : '0;

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk     (clka),
        .i_be    (w_wr_be),
        .i_idx   (w_idx),
        .i_wdata (r_req.wdata),
        .o_rdata (w_rd_word)
    );

    always_ff @(posedge clka or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_req   <= '0;
            r_rdata <= '0;
            r_ready <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.req) begin
                        r_req.we    <= bus.we;
                        r_req.addr  <= bus.addr;
                        r_req.wdata <= bus.wdata;
                        r_req.be    <= w_in_be;
                        r_cnt       <= CNT_INIT;
                        r_state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        // Stores and misaligned accesses return zero data.
                        r_rdata <= (!r_req.we && !w_misal) ? w_rd_word : '0;
                        r_err   <= w_misal;
                        r_ready <= 1'b1;
                        r_state <= RESP;
                    end
                end
                RESP: begin
                    r_ready <= 1'b0;
                    r_rdata <= '0;
                    r_err   <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.rdata = r_rdata;
    assign bus.ready = r_ready;
    assign bus.err   = r_err;
    assign bus.stall = bus.req & ~r_ready;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios plus randomized
// traffic against an associative-array memory model.
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam int DEPTH = 256;
    localparam int W     = 1;

    logic clka = 1'b0;
    logic rst  = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [31:0] model_mem [int];

    dmem_responder_if bus();

    dmem_responder #(
        .DEPTH_WORDS (DEPTH),
        .WAIT_CYCLES (W)
    ) dut (
        .clka (clka),
        .rst  (rst),
        .bus  (bus)
    );

    always #5 clka = ~clka;

    function automatic int word_idx(input logic [31:0] a);
        return int'((a / 32'd4) % DEPTH);
    endfunction

    // Reference: returns expected err; updates model on aligned stores.
    function automatic logic model_store(input logic [31:0] a, input logic [31:0] d,
                                         input logic [3:0] be);
        logic [31:0] cur;
        if (a[1:0] != 2'b00) return 1'b1;
        cur = model_mem.exists(word_idx(a)) ? model_mem[word_idx(a)] : 32'h0;
        for (int b = 0; b < 4; b++)
            if (be[b]) cur[8*b +: 8] = d[8*b +: 8];
        if (be != 4'b0000) model_mem[word_idx(a)] = cur;
        return 1'b0;
    endfunction

    task automatic do_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] be, output logic [31:0] rd, output logic er,
                             output int lat, output int stall_bad);
        logic got;
        @(negedge clka);
        bus.req = 1'b1; bus.we = we; bus.addr = addr; bus.wdata = wdata;
`ifdef DMEM_BYTE_STROBE_EN
        bus.be = be;
`endif
        lat = 0; got = 1'b0; stall_bad = 0;
        while (!got && lat < 64) begin
            @(posedge clka);
            lat++;
            @(negedge clka);
            if (lat == 1) begin
                bus.we = $urandom_range(0, 1) != 0; bus.addr = $urandom; bus.wdata = $urandom;
`ifdef DMEM_BYTE_STROBE_EN
                bus.be = 4'($urandom);
`endif
            end
            if (bus.ready === 1'b1) got = 1'b1;
            else if (bus.stall !== 1'b1) stall_bad++;
        end
        rd = bus.rdata; er = bus.err;
        bus.req = 1'b0;
        if (!got) lat = -1;
    endtask

    task automatic test_reset;
        @(negedge clka);
        n_checks++;
        if ({bus.ready, bus.err, bus.stall} !== 3'b000 || bus.rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: ready=%b err=%b stall=%b rdata=%h, required all zero",
                     bus.ready, bus.err, bus.stall, bus.rdata);
        end
        @(negedge clka); rst = 1'b1;
    endtask

    task automatic test_store_load;
        logic [31:0] rd; logic er; int lat, sb;
        do_access(1'b1, 32'h40, 32'h12345678, 4'hF, rd, er, lat, sb);
        void'(model_store(32'h40, 32'h12345678, 4'hF));
        n_checks++;
        if (lat != W + 2 || er !== 1'b0 || rd !== 32'h0 || sb != 0) begin
            n_fail++;
            $display("FAIL store_0x40: lat=%0d err=%b rdata=%h stall_bad=%0d, required lat=%0d err=0 rdata=0 stall_bad=0",
                     lat, er, rd, sb, W + 2);
        end
        do_access(1'b0, 32'h40, 32'h0, 4'h0, rd, er, lat, sb);
        n_checks++;
        if (lat != W + 2 || er !== 1'b0 || rd !== 32'h12345678 || sb != 0) begin
            n_fail++;
            $display("FAIL load_0x40: lat=%0d err=%b rdata=%h stall_bad=%0d, required lat=%0d err=0 rdata=12345678",
                     lat, er, rd, sb, W + 2);
        end
    endtask

    task automatic test_misaligned;
        logic [31:0] rd; logic er; int lat, sb;
        do_access(1'b1, 32'h42, 32'hFFFFFFFF, 4'hF, rd, er, lat, sb);
        n_checks++;
        if (lat != W + 2 || er !== 1'b1 || rd !== 32'h0) begin
            n_fail++;
            $display("FAIL misaligned_store: lat=%0d err=%b rdata=%h, required lat=%0d err=1 rdata=0",
                     lat, er, rd, W + 2);
        end
        do_access(1'b0, 32'h40, 32'h0, 4'h0, rd, er, lat, sb);
        n_checks++;
        if (er !== 1'b0 || rd !== model_mem[word_idx(32'h40)]) begin
            n_fail++;
            $display("FAIL misaligned_no_write: err=%b rdata=%h, required err=0 rdata=%h",
                     er, rd, model_mem[word_idx(32'h40)]);
        end
    endtask

    task automatic test_wrap;
        logic [31:0] rd; logic er; int lat, sb;
        logic [31:0] hi_addr;
        hi_addr = 32'(DEPTH * 4);
        do_access(1'b1, hi_addr, 32'hA5A5A5A5, 4'hF, rd, er, lat, sb);
        void'(model_store(hi_addr, 32'hA5A5A5A5, 4'hF));
        do_access(1'b0, 32'h0, 32'h0, 4'h0, rd, er, lat, sb);
        n_checks++;
        if (er !== 1'b0 || rd !== 32'hA5A5A5A5) begin
            n_fail++;
            $display("FAIL wrap_load_0x0: err=%b rdata=%h, required err=0 rdata=a5a5a5a5", er, rd);
        end
    endtask

    task automatic test_reset_midflight;
        logic [31:0] rd; logic er; int lat, sb;
        do_access(1'b1, 32'h10, 32'h0BADF00D, 4'hF, rd, er, lat, sb);
        void'(model_store(32'h10, 32'h0BADF00D, 4'hF));
        @(negedge clka);
        bus.req = 1'b1; bus.we = 1'b1; bus.addr = 32'h10; bus.wdata = 32'hDEADBEEF;
`ifdef DMEM_BYTE_STROBE_EN
        bus.be = 4'hF;
`endif
        @(posedge clka);
        @(negedge clka);
        rst = 1'b0;
        #1;
        n_checks++;
        if (bus.ready !== 1'b0 || bus.err !== 1'b0 || bus.rdata !== 32'h0 || dut.r_state !== IDLE) begin
            n_fail++;
            $display("FAIL reset_midflight: ready=%b err=%b rdata=%h state=%0d, required 0/0/0/IDLE",
                     bus.ready, bus.err, bus.rdata, dut.r_state);
        end
        bus.req = 1'b0;
        repeat (2) @(posedge clka);
        @(negedge clka); rst = 1'b1;
        do_access(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat, sb);
        n_checks++;
        if (rd !== 32'h0BADF00D || er !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_dropped_write: rdata=%h err=%b, required rdata=0badf00d err=0", rd, er);
        end
    endtask

    task automatic test_back_to_back;
        int t [4];
        int n, cyc, extra;
        logic [31:0] exp_rd;
        exp_rd = model_mem[word_idx(32'h40)];
        n = 0; cyc = 0; extra = 0;
        @(negedge clka);
        bus.req = 1'b1; bus.we = 1'b0; bus.addr = 32'h40;
        while (n < 4 && cyc < 200) begin
            @(posedge clka); cyc++;
            @(negedge clka);
            if (bus.ready === 1'b1) begin
                t[n] = cyc;
                n_checks++;
                if (bus.rdata !== exp_rd || bus.err !== 1'b0) begin
                    n_fail++;
                    $display("FAIL b2b_data[%0d]: rdata=%h err=%b, required rdata=%h err=0",
                             n, bus.rdata, bus.err, exp_rd);
                end
                n++;
                if (n == 4) bus.req = 1'b0;
            end
        end
        n_checks++;
        if (n != 4) begin
            n_fail++;
            $display("FAIL b2b_count: pulses=%0d, required 4", n);
        end else begin
            for (int i = 1; i < 4; i++) begin
                n_checks++;
                if (t[i] - t[i-1] != W + 3) begin
                    n_fail++;
                    $display("FAIL b2b_spacing[%0d]: spacing=%0d, required %0d", i, t[i] - t[i-1], W + 3);
                end
            end
        end
        for (int i = 0; i < W + 5; i++) begin
            @(negedge clka);
            if (bus.ready !== 1'b0) extra++;
        end
        n_checks++;
        if (extra != 0) begin
            n_fail++;
            $display("FAIL b2b_no_extra: extra_ready=%0d, required 0", extra);
        end
    endtask

`ifdef DMEM_BYTE_STROBE_EN
    task automatic test_strobe;
        logic [31:0] rd; logic er; int lat, sb;
        do_access(1'b1, 32'h80, 32'h11223344, 4'hF, rd, er, lat, sb);
        void'(model_store(32'h80, 32'h11223344, 4'hF));
        do_access(1'b1, 32'h80, 32'hAABBCCDD, 4'b0101, rd, er, lat, sb);
        void'(model_store(32'h80, 32'hAABBCCDD, 4'b0101));
        do_access(1'b0, 32'h80, 32'h0, 4'hF, rd, er, lat, sb);
        n_checks++;
        if (rd !== 32'h11BB33DD || er !== 1'b0) begin
            n_fail++;
            $display("FAIL strobe_0101: rdata=%h err=%b, required rdata=11bb33dd err=0", rd, er);
        end
        do_access(1'b1, 32'h80, 32'hFFFFFFFF, 4'b0000, rd, er, lat, sb);
        n_checks++;
        if (er !== 1'b0) begin
            n_fail++;
            $display("FAIL strobe_zero_err: err=%b, required 0", er);
        end
        do_access(1'b0, 32'h80, 32'h0, 4'h0, rd, er, lat, sb);
        n_checks++;
        if (rd !== 32'h11BB33DD) begin
            n_fail++;
            $display("FAIL strobe_zero_nowrite: rdata=%h, required 11bb33dd", rd);
        end
    endtask
`endif

    task automatic test_random;
        logic [31:0] rd, a, d, exp_rd; logic er, we, exp_er; logic [3:0] be; int lat, sb, idx;
        for (int i = 0; i < 8; i++) begin
            a = 32'((32'h60 + i) * 4);
            d = $urandom;
            do_access(1'b1, a, d, 4'hF, rd, er, lat, sb);
            void'(model_store(a, d, 4'hF));
        end
        for (int k = 0; k < 40; k++) begin
            idx = 32'h60 + $urandom_range(0, 7);
            a   = 32'(idx * 4) + 32'($urandom_range(0, 3) * DEPTH * 4);
            if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
            we = $urandom_range(0, 1) != 0;
            d  = $urandom;
`ifdef DMEM_BYTE_STROBE_EN
            be = 4'($urandom);
`else
            be = 4'hF;
`endif
            if (we) begin
                exp_er = model_store(a, d, be);
                exp_rd = 32'h0;
            end else begin
                exp_er = (a[1:0] != 2'b00);
                exp_rd = exp_er ? 32'h0 : model_mem[word_idx(a)];
            end
            do_access(we, a, d, be, rd, er, lat, sb);
            n_checks++;
            if (lat != W + 2 || rd !== exp_rd || er !== exp_er || sb != 0) begin
                n_fail++;
                $display("FAIL random[%0d] we=%b addr=%h: lat=%0d rdata=%h err=%b stall_bad=%0d, required lat=%0d rdata=%h err=%b",
                         k, we, a, lat, rd, er, sb, W + 2, exp_rd, exp_er);
            end
        end
    endtask

    initial begin
        bus.req = 1'b0; bus.we = 1'b0; bus.addr = 32'h0; bus.wdata = 32'h0;
`ifdef DMEM_BYTE_STROBE_EN
        bus.be = 4'h0;
`endif
        test_reset();
        test_store_load();
        test_misaligned();
        test_wrap();
        test_reset_midflight();
        test_back_to_back();
`ifdef DMEM_BYTE_STROBE_EN
        test_strobe();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
